// File: rtl/jt51_slot_wr.sv
// Write injector for a 32-slot shift ring: queues slot-addressed writes and merges each one into the ring data when its slot comes round.
// Optional readback port enabled by defining JT51_SLOT_RDBK_EN.
module jt51_slot_wr #(
  parameter int   WIDTH  = 5,
  parameter int   STAGES = 32,
  parameter int   DEPTH  = 4,
  parameter logic RSTVAL = 1'b0,
  localparam int  SW     = $clog2(STAGES)
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             cen,
  input  logic             wr_req,
  input  logic [SW-1:0]    wr_slot,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic [WIDTH-1:0] ring_in,
`ifdef JT51_SLOT_RDBK_EN
  input  logic             rd_req,
  input  logic [SW-1:0]    rd_slot,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
`endif
  output logic [WIDTH-1:0] ring_out,
  output logic [SW-1:0]    cur_slot,
  output logic             zero,
  output logic             full,
  output logic             empty,
  output logic             wr_done
);

  localparam int PW = $clog2(DEPTH);

  logic [SW-1:0]    r_slot;
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [PW:0]      r_cnt;
  logic             r_done;
  logic [SW-1:0]    r_q_slot [DEPTH];
  logic [WIDTH-1:0] r_q_data [DEPTH];
  logic [WIDTH-1:0] r_q_mask [DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_hit;
  logic [SW-1:0]    w_head_slot;
  logic [WIDTH-1:0] w_head_data;
  logic [WIDTH-1:0] w_head_mask;
  logic [WIDTH-1:0] w_ring_out;

  // Flags come from the registered count only, so a pop cannot open room for a push on the same edge.
  assign w_full      = (r_cnt == (PW+1)'(DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_head_slot = r_q_slot[r_rp];
  assign w_head_data = r_q_data[r_rp];
  assign w_head_mask = r_q_mask[r_rp];
  assign w_hit       = !w_empty && (w_head_slot == r_slot) && !rst;
  assign w_push      = wr_req && !w_full;
  assign w_pop       = cen && w_hit;

  always_comb begin
    w_ring_out = ring_in;
    if (rst)
      w_ring_out = {WIDTH{RSTVAL}};
    else if (w_hit)
      w_ring_out = (ring_in & ~w_head_mask) | (w_head_data & w_head_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      if (cen)
        r_slot <= r_slot + 1'b1;
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - 1'b1;
      r_done <= w_pop;
    end
  end

  // Queue storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_slot[r_wp] <= wr_slot;
      r_q_data[r_wp] <= wr_data;
      r_q_mask[r_wp] <= wr_mask;
    end
  end

`ifdef JT51_SLOT_RDBK_EN
  logic             r_rd_pend;
  logic [SW-1:0]    r_rd_slot;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  // A read captures the post-merge value, so it reflects a write landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_slot  <= '0;
      r_rd_data  <= {WIDTH{RSTVAL}};
      r_rd_valid <= 1'b0;
    end else if (rd_req && !r_rd_pend) begin
      r_rd_pend  <= 1'b1;
      r_rd_slot  <= rd_slot;
      r_rd_valid <= 1'b0;
    end else if (r_rd_pend && cen && (r_slot == r_rd_slot)) begin
      r_rd_pend  <= 1'b0;
      r_rd_data  <= w_ring_out;
      r_rd_valid <= 1'b1;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`endif

  assign ring_out = w_ring_out;
  assign cur_slot = r_slot;
  assign zero     = (r_slot == '0);
  assign full     = w_full;
  assign empty    = w_empty;
  assign wr_done  = r_done;

endmodule

// File: tb/tb_jt51_slot_wr.sv
// Directed bench for jt51_slot_wr: stimulus pushes expected merges into a queue, a negedge monitor checks each wr_done pulse.
module tb_jt51_slot_wr;

  localparam int WIDTH = 5;
  localparam int SW    = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cen = 1'b0;
  logic             wr_req = 1'b0;
  logic [SW-1:0]    wr_slot = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] wr_mask = '0;
  logic [WIDTH-1:0] ring_in;
  logic [WIDTH-1:0] ring_out;
  logic [SW-1:0]    cur_slot;
  logic             zero;
  logic             full;
  logic             empty;
  logic             wr_done;

  logic [WIDTH-1:0] ring_pat [32];
  logic [SW+WIDTH-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  jt51_slot_wr dut (
    .rst(rst), .clk(clk), .cen(cen),
    .wr_req(wr_req), .wr_slot(wr_slot), .wr_data(wr_data), .wr_mask(wr_mask),
    .ring_in(ring_in), .ring_out(ring_out), .cur_slot(cur_slot),
    .zero(zero), .full(full), .empty(empty), .wr_done(wr_done)
  );

  // Clock / reset
  always #5 clk = ~clk;
  assign ring_in = ring_pat[cur_slot];

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_slot(input int s);
    cen = 1'b1;
    for (int i = 0; i < 64 && cur_slot != s[SW-1:0]; i++) tick();
    chk("goto_slot", cur_slot, s);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (wr_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_wr(input int s, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
    wr_req  = 1'b1;
    wr_slot = s[SW-1:0];
    wr_data = d;
    wr_mask = m;
  endtask

  // Scoreboard monitor
  logic [SW-1:0]    prev_slot = '0;
  logic [WIDTH-1:0] prev_out  = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wr_done", 1, 0);
        end else begin
          logic [SW+WIDTH-1:0] e;
          e = exp_q.pop_front();
          chk("merge_slot", prev_slot, e[SW+WIDTH-1:WIDTH]);
          chk("merge_data", prev_out, e[WIDTH-1:0]);
        end
      end else if (exp_q.size() == 0) begin
        chk("pass_through", ring_out, ring_in);
      end
    end
    prev_slot = cur_slot;
    prev_out  = ring_out;
  end

  initial begin
    int n;
    int cnt;
    for (int i = 0; i < 32; i++) ring_pat[i] = '0;
    ring_pat[0] = 5'h1F;

    // Reset state
    tick();
    tick();
    chk("rst_ring_out", ring_out, 5'h00);
    chk("rst_cur_slot", cur_slot, 0);
    chk("rst_zero", zero, 1);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_wr_done", wr_done, 0);
    rst = 1'b0;
    ring_pat[0] = '0;

    // Rotation: 70 cen edges
    cen = 1'b1;
    for (int i = 0; i < 70; i++) begin
      chk("rot_slot", cur_slot, i % 32);
      chk("rot_zero", zero, (i % 32) == 0);
      tick();
    end
    chk("rot_end_slot", cur_slot, 6);

    // Single full-mask write to slot 7 issued at slot 2
    goto_slot(2);
    set_wr(7, 5'h15, 5'h1F);
    exp_q.push_back({5'd7, 5'h15});
    tick();
    wr_req = 1'b0;
    wait_done(40, n);
    chk("single_latency", n, 5);
    tick();
    chk("single_pulse_once", wr_done, 0);
    chk("single_empty", empty, 1);

    // Masked merge at slot 3
    ring_pat[3] = 5'h0A;
    goto_slot(9);
    set_wr(3, 5'h11, 5'h03);
    exp_q.push_back({5'd3, 5'h09});
    tick();
    wr_req = 1'b0;
    wait_done(40, n);
    chk("masked_latency", n, 26);
    ring_pat[3] = '0;

    // Full and ordering with cen held low while filling
    goto_slot(10);
    cen = 1'b0;
    set_wr(4, 5'h01, 5'h1F);
    exp_q.push_back({5'd4, 5'h01});
    tick();
    chk("fill1_empty", empty, 0);
    chk("fill1_full", full, 0);
    set_wr(4, 5'h02, 5'h1F);
    exp_q.push_back({5'd4, 5'h02});
    tick();
    set_wr(1, 5'h03, 5'h1F);
    exp_q.push_back({5'd1, 5'h03});
    tick();
    chk("fill3_full", full, 0);
    set_wr(9, 5'h04, 5'h1F);
    exp_q.push_back({5'd9, 5'h04});
    tick();
    chk("fill4_full", full, 1);
    set_wr(2, 5'h05, 5'h1F);
    tick();
    chk("fill5_full", full, 1);
    chk("hold_slot", cur_slot, 10);
    wr_req = 1'b0;
    cen = 1'b1;
    wait_done(40, n);
    chk("order_lat_slot4a", n, 27);
    wait_done(40, n);
    chk("order_lat_slot4b", n, 32);
    wait_done(40, n);
    chk("order_lat_slot1", n, 29);
    wait_done(40, n);
    chk("order_lat_slot9", n, 8);
    chk("order_empty", empty, 1);
    chk("order_not_full", full, 0);

    // Same-slot write into an empty queue waits a full rotation
    goto_slot(5);
    set_wr(5, 5'h1B, 5'h1F);
    exp_q.push_back({5'd5, 5'h1B});
    tick();
    wr_req = 1'b0;
    chk("same_slot_no_done", wr_done, 0);
    wait_done(40, n);
    chk("same_slot_latency", n, 32);

    // Reset mid-flight discards queued writes
    cen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_wr(20 + i, 5'h1F, 5'h1F);
      tick();
    end
    wr_req = 1'b0;
    chk("pre_rst_empty", empty, 0);
    for (int i = 0; i < 32; i++) ring_pat[i] = 5'h1F;
    rst = 1'b1;
    #1;
    chk("midrst_ring_out", ring_out, 5'h00);
    chk("midrst_cur_slot", cur_slot, 0);
    tick();
    rst = 1'b0;
    chk("post_rst_empty", empty, 1);
    chk("post_rst_full", full, 0);
    chk("post_rst_slot", cur_slot, 0);
    chk("post_rst_zero", zero, 1);
    cen = 1'b1;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (wr_done) cnt++;
    end
    chk("post_rst_no_done", cnt, 0);

    tick();
    chk("exp_q_drained", exp_q.size(), 0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt51_slot_wr.md
Name: jt51_slot_wr

Overview:
- Write injector on the input side of a 32-stage per-slot shift ring.
- Sits between the register/CPU write path and the ring's shift register:
  - takes the ring's drop output as ring_in;
  - drives the ring's din from ring_out.
- Queues slot-addressed writes and merges each into the circulating data when its target slot comes round.
- Also provides the slot counter and the frame-start marker.

Parameters:
- WIDTH, 5: data width of the ring.
- STAGES, 32: slots per rotation; must be a power of two, at least 2. Slot counter width SW = log2(STAGES).
- DEPTH, 4: pending-write queue entries; must be a power of two, at least 2.
- RSTVAL, 1'b0: bit value loaded into ring_out during reset.

Ports:
- rst  in  1  asynchronous reset, active-high.
- clk  in  1  clock (the only clock).
- cen  in  1  clock enable; slot advance and ring shift happen only on clk edges with cen=1.
- wr_req  in  1  write request; accepted on any clk edge where wr_req=1 and full=0 (cen not required).
- wr_slot  in  SW  target slot.
- wr_data  in  WIDTH  write value.
- wr_mask  in  WIDTH  per-bit enable; 1 replaces the ring bit, 0 keeps it.
- ring_in  in  WIDTH  ring drop output; value of slot cur_slot.
- ring_out  out  WIDTH  ring din.
- cur_slot  out  SW  slot currently presented on ring_in/ring_out.
- zero  out  1  high while cur_slot==0.
- full  out  1  queue holds DEPTH entries; registered.
- empty  out  1  queue holds 0 entries; registered.
- wr_done  out  1  one-clk pulse on the edge where a queued write is merged.

Behaviour:
- Reset (async assert, sync release): cur_slot=0, zero=1, full=0, empty=1, wr_done=0. Queue pointers and count cleared; queued writes discarded. ring_out={WIDTH{RSTVAL}} while rst=1, overriding the merge path.
- Slot counter:
  - cur_slot increments by 1 on each clk edge with cen=1; wraps STAGES-1 -> 0.
  - Holds when cen=0.
  - zero is decoded from the registered counter.
- Queue:
  - FIFO of {slot, data, mask}.
  - Write pointer, read pointer and occupancy count are registers.
  - full/empty are derived from the registered count.
- Push: wr_req=1 and full=0 at a clk edge stores the entry. wr_req while full=1 is dropped silently; no entry, no flag.
- Head match (combinational): hit = !empty && head.slot==cur_slot && !rst.
- Merge path (combinational): ring_out = hit ? (ring_in & ~head.mask) | (head.data & head.mask) : ring_in.
- Pop: on a clk edge with cen=1 and hit=1, the head is popped and wr_done=1 for that clk. Otherwise wr_done=0.
- Ordering:
  - Only the head is compared; writes apply strictly in acceptance order.
  - Two queued writes to the same slot apply on successive rotations.
  - A later write to an earlier slot waits behind the head.
- Latency:
  - Entry at head with slot s is applied at the first cen edge where cur_slot==s.
  - If the queue was empty and s==cur_slot at the accepting edge, that same edge does not apply it (the head was empty while hit was decoded). It applies one full rotation later: STAGES cen edges.
  - Worst case per entry is STAGES cen edges after reaching the head.
- Simultaneous push and pop on one edge: both happen, count unchanged. A push in the same edge as a pop from a full queue is still refused (full is registered).
- cen=0: no pop and no slot advance. ring_out stays combinational, so the ring register ignores it.
- rst mid-operation: pending entries are lost, no wr_done pulse, counter restarts at 0.

Optional Feature:
- Macro: JT51_SLOT_RDBK_EN.
- With the macro, add these ports:
  - rd_req  in  1
  - rd_slot  in  SW
  - rd_data  out  WIDTH
  - rd_valid  out  1
- Readback behaviour:
  - rd_req=1 with no read outstanding latches rd_slot and clears rd_valid.
  - rd_req=1 while a read is outstanding is ignored.
  - At the next cen edge with cur_slot==latched slot, rd_data captures the post-merge ring_out and rd_valid=1. rd_valid stays high until the next accepted rd_req.
  - Reset: rd_data={WIDTH{RSTVAL}}, rd_valid=0, no read outstanding.
- Without the macro: no extra ports and no readback logic.

Test Plan:
- Rotation: cen=1 every clk, STAGES=32, 70 clks -> cur_slot sequence 0..31,0..31,0..5; zero high on clks 0, 32 and 64 only.
- Single write: ring_in=0, write slot 7, data 5'h15, mask 5'h1F while cur_slot=2 -> at cur_slot=7, ring_out=5'h15 and wr_done pulses once; all other slots pass ring_in unchanged.
- Masked merge: ring_in=5'h0A at slot 3, write data 5'h11, mask 5'h03 -> ring_out=5'h09 at slot 3.
- Full/order: cen=0, five writes to slots 4,4,1,9,2 -> full=1 after the fourth; fifth dropped. Then cen=1 -> slot 4 applied first, second slot-4 write 32 cens later at slot 4, then slot 1, then slot 9; empty=1 after.
- Same-slot edge: empty queue, write slot 5 on the accepting edge where cur_slot=5 with cen=1 -> applied 32 cen edges later, not on that edge.
- Reset mid-flight: three entries queued, assert rst for 1 clk -> ring_out=RSTVAL during reset; afterwards empty=1, cur_slot=0, no wr_done for 64 cens.
